test_ctrl_watchdog: RTL and testbench

- Synthesizable test-harness controller that sequences a simulation run of the microISA-16 core.
- The core, or bench BFM, drives a small register interface to start a test, kick the watchdog and report a pass/fail result.
- The block owns the run state machine, watchdog countdown and cycle counter, and presents sticky done/pass/fail/timeout flags to the bench's logging tasks.
- Replaces free-running bench timeouts with a core-visible, kickable watchdog.

---
 rtl/test_ctrl_watchdog.sv | 175 +++++++++++++++++
 tb/tb_test_ctrl_watchdog.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_ctrl_watchdog.sv
// test_ctrl_watchdog: run sequencer for microISA-16 simulations.
// A small register interface starts a run, kicks the watchdog and reports
// the result; the block keeps the run state, a reloadable watchdog countdown,
// a saturating cycle counter and sticky done/pass/fail/timeout flags.
module test_ctrl_watchdog #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [2:0]            state_o,
    output logic                  test_done,
    output logic                  test_pass,
    output logic                  test_fail,
    output logic                  test_timeout,
    output logic [DATA_WIDTH-1:0] fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUNNING = 3'd1,
        PASSED  = 3'd2,
        FAILED  = 3'd3,
        TIMEOUT = 3'd4
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_RESULT = 2'd1;
    localparam logic [1:0] ADDR_RELOAD = 2'd2;
    localparam logic [1:0] ADDR_CNTHI  = 2'd3;

    localparam logic [DATA_WIDTH-1:0] RELOAD_INIT = DATA_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] WDOG_ONE    = DATA_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);

    state_t                  state;
    state_t                  next_state;
    logic [DATA_WIDTH-1:0]   reload;
    logic [DATA_WIDTH-1:0]   wdog;
    logic                    start_req;
    logic                    kick_req;
    logic                    result_wr;
    logic                    result_fail;
    logic                    reload_wr;
    logic [DATA_WIDTH-1:0]   rd_mux;

    assign state_o = state;

    // Decode the write strobe into the individual register commands.
    always_comb begin
        start_req   = wr_en && (wr_addr == ADDR_CTRL) && wr_data[0];
        kick_req    = wr_en && (wr_addr == ADDR_CTRL) && wr_data[1];
        result_wr   = wr_en && (wr_addr == ADDR_RESULT);
        result_fail = result_wr && (wr_data != '0);
        reload_wr   = wr_en && (wr_addr == ADDR_RELOAD) && (wr_data != '0);
    end

    // Next-state logic; a result beats a kick, and a kick beats expiry.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_req) begin
                    next_state = RUNNING;
                end
            end
            RUNNING: begin
                if (result_wr) begin
                    if (result_fail) begin
                        next_state = FAILED;
                    end else begin
                        next_state = PASSED;
                    end
                end else if (!kick_req && (wdog == WDOG_ONE)) begin
                    next_state = TIMEOUT;
                end
            end
            default: begin
                next_state = state;
            end
        endcase
    end

    // State register with the status flags registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            test_done    <= 1'b0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            test_timeout <= 1'b0;
        end else begin
            state        <= next_state;
            test_pass    <= (next_state == PASSED);
            test_fail    <= (next_state == FAILED);
            test_timeout <= (next_state == TIMEOUT);
            test_done    <= (next_state == PASSED) || (next_state == FAILED) ||
                            (next_state == TIMEOUT);
        end
    end

    // Watchdog reload value; writable in any state, zero writes dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload <= RELOAD_INIT;
        end else if (reload_wr) begin
            reload <= wr_data;
        end
    end

    // Watchdog countdown and run-cycle counter, frozen outside RUNNING.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog        <= RELOAD_INIT;
            cycle_count <= '0;
        end else if ((state == IDLE) && start_req) begin
            wdog        <= reload;
            cycle_count <= '0;
        end else if (state == RUNNING) begin
            if (cycle_count != CNT_MAX) begin
                cycle_count <= cycle_count + CNT_ONE;
            end
            if (kick_req) begin
                wdog <= reload;
            end else if (wdog != '0) begin
                wdog <= wdog - WDOG_ONE;
            end
        end
    end

    // Latch the failure code only when a run ends in FAILED.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_code <= '0;
        end else if ((state == RUNNING) && result_fail) begin
            fail_code <= wr_data;
        end
    end

    // Read-side register selection from current (pre-write) values.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_CTRL:   rd_mux = DATA_WIDTH'(state_o);
            ADDR_RESULT: rd_mux = fail_code;
            ADDR_RELOAD: rd_mux = DATA_WIDTH'(cycle_count[15:0]);
            ADDR_CNTHI:  rd_mux = DATA_WIDTH'(cycle_count >> 16);
            default:     rd_mux = '0;
        endcase
    end

    // One-cycle read response path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_test_ctrl_watchdog.sv
// tb_test_ctrl_watchdog: scenario tasks for the run controller; read
// responses are checked against a queue of expected values.
module tb_test_ctrl_watchdog;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam int TO = 1000;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_RESULT = 2'd1;
    localparam logic [1:0] A_RELOAD = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = 2'd0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_addr = 2'd0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [2:0]    state_o;
    logic          test_done;
    logic          test_pass;
    logic          test_fail;
    logic          test_timeout;
    logic [DW-1:0] fail_code;
    logic [CW-1:0] cycle_count;

    int n_total = 0;
    int n_pass  = 0;
    logic [DW-1:0] exp_q[$];

    test_ctrl_watchdog #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .state_o     (state_o),
        .test_done   (test_done),
        .test_pass   (test_pass),
        .test_fail   (test_fail),
        .test_timeout(test_timeout),
        .fail_code   (fail_code),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Present a write for exactly one rising edge (called at a negedge).
    task automatic do_write(input logic [1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Four back-to-back reads; expectations queued as each read is issued.
    task automatic test_back_to_back(input string tag, input logic [DW-1:0] e0,
                                     input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                                     input logic [DW-1:0] e3);
        logic [DW-1:0] ev [4];
        logic [DW-1:0] want;
        ev = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            rd_en   = 1'b1;
            rd_addr = 2'(i);
            exp_q.push_back(ev[i]);
            @(negedge clk);
            n_total++;
            if (rd_valid !== 1'b1) begin
                $display("[TB] FAIL %s_rd%0d_valid: got %b want 1", tag, i, rd_valid);
            end else begin
                want = exp_q.pop_front();
                if (rd_data !== want)
                    $display("[TB] FAIL %s_rd%0d_data: got %h want %h", tag, i, rd_data, want);
                else
                    n_pass++;
            end
        end
        rd_en = 1'b0;
        @(negedge clk);
        n_total++;
        if (rd_valid !== 1'b0) $display("[TB] FAIL %s_rd_idle: got %b want 0", tag, rd_valid);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        @(negedge clk);
        n_total++;
        if (state_o !== 3'd0) $display("[TB] FAIL reset_state: got %0d want 0", state_o);
        else n_pass++;
        n_total++;
        if ({test_done, test_pass, test_fail, test_timeout} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b want 0000",
                     {test_done, test_pass, test_fail, test_timeout});
        else n_pass++;
        n_total++;
        if (fail_code !== '0 || cycle_count !== '0)
            $display("[TB] FAIL reset_regs: got code %h count %0d want 0 0", fail_code, cycle_count);
        else n_pass++;
        n_total++;
        if (rd_valid !== 1'b0 || rd_data !== '0)
            $display("[TB] FAIL reset_rd: got valid %b data %h want 0 0", rd_valid, rd_data);
        else n_pass++;
        rst = 1'b0;
    endtask

    // IDLE ignores RESULT; a read issued with START returns the pre-write state.
    task automatic test_idle_and_same_cycle;
        do_write(A_RESULT, 16'h0007);
        n_total++;
        if (state_o !== 3'd0 || fail_code !== '0)
            $display("[TB] FAIL idle_result: got state %0d code %h want 0 0", state_o, fail_code);
        else n_pass++;
        rd_en   = 1'b1;
        rd_addr = A_CTRL;
        exp_q.push_back(16'd0);
        do_write(A_CTRL, 16'h0001);
        rd_en = 1'b0;
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== exp_q.pop_front())
            $display("[TB] FAIL same_cycle_read: got valid %b data %h want 1 0000", rd_valid, rd_data);
        else n_pass++;
        n_total++;
        if (state_o !== 3'd1) $display("[TB] FAIL same_cycle_start: got %0d want 1", state_o);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_pass_flow;
        do_reset();
        do_write(A_CTRL, 16'h0001);
        idle(10);
        do_write(A_RESULT, 16'h0000);
        n_total++;
        if (state_o !== 3'd2 || test_pass !== 1'b1 || test_done !== 1'b1 ||
            test_fail !== 1'b0 || test_timeout !== 1'b0)
            $display("[TB] FAIL pass_state: got state %0d flags %b want 2 1100", state_o,
                     {test_done, test_pass, test_fail, test_timeout});
        else n_pass++;
        n_total++;
        if (cycle_count !== 32'd11) $display("[TB] FAIL pass_count: got %0d want 11", cycle_count);
        else n_pass++;
        n_total++;
        if (fail_code !== '0) $display("[TB] FAIL pass_code: got %h want 0", fail_code);
        else n_pass++;
        idle(5);
        n_total++;
        if (cycle_count !== 32'd11) $display("[TB] FAIL pass_frozen: got %0d want 11", cycle_count);
        else n_pass++;
        test_back_to_back("pass", 16'd2, 16'd0, 16'd11, 16'd0);
    endtask

    task automatic test_fail_flow;
        do_reset();
        do_write(A_CTRL, 16'h0001);
        idle(4);
        do_write(A_RESULT, 16'h00AB);
        n_total++;
        if (state_o !== 3'd3 || test_fail !== 1'b1 || test_done !== 1'b1 || test_pass !== 1'b0)
            $display("[TB] FAIL fail_state: got state %0d flags %b want 3 1010", state_o,
                     {test_done, test_pass, test_fail, test_timeout});
        else n_pass++;
        n_total++;
        if (fail_code !== 16'h00AB || cycle_count !== 32'd5)
            $display("[TB] FAIL fail_regs: got code %h count %0d want 00ab 5", fail_code, cycle_count);
        else n_pass++;
        do_write(A_RESULT, 16'h0000);
        do_write(A_CTRL, 16'h0003);
        do_write(A_RESULT, 16'h0055);
        n_total++;
        if (state_o !== 3'd3 || fail_code !== 16'h00AB || cycle_count !== 32'd5)
            $display("[TB] FAIL fail_sticky: got state %0d code %h count %0d want 3 00ab 5",
                     state_o, fail_code, cycle_count);
        else n_pass++;
        test_back_to_back("fail", 16'd3, 16'h00AB, 16'd5, 16'd0);
    endtask

    task automatic test_timeout_flow;
        int hit;
        do_reset();
        do_write(A_RELOAD, 16'd8);
        do_write(A_CTRL, 16'h0001);
        hit = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (hit < 0 && state_o === 3'd4) hit = i;
        end
        n_total++;
        if (hit != 8) $display("[TB] FAIL timeout_latency: got %0d want 8", hit);
        else n_pass++;
        n_total++;
        if (cycle_count !== 32'd8 || test_timeout !== 1'b1 || test_done !== 1'b1 || test_pass !== 1'b0)
            $display("[TB] FAIL timeout_regs: got count %0d flags %b want 8 1001", cycle_count,
                     {test_done, test_pass, test_fail, test_timeout});
        else n_pass++;
    endtask

    task automatic test_kick;
        int hit;
        bit left;
        do_reset();
        do_write(A_RELOAD, 16'd4);
        do_write(A_RELOAD, 16'd0);
        do_write(A_CTRL, 16'h0001);
        left = 1'b0;
        for (int k = 0; k < 13; k++) begin
            idle(2);
            if (state_o !== 3'd1) left = 1'b1;
            do_write(A_CTRL, 16'h0002);
            if (state_o !== 3'd1) left = 1'b1;
        end
        n_total++;
        if (left || state_o !== 3'd1)
            $display("[TB] FAIL kick_running: got state %0d left %0d want 1 0", state_o, left);
        else n_pass++;
        hit = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (hit < 0 && state_o === 3'd4) hit = i;
        end
        n_total++;
        if (hit != 4) $display("[TB] FAIL kick_expiry: got %0d want 4", hit);
        else n_pass++;
        n_total++;
        if (cycle_count !== 32'd43) $display("[TB] FAIL kick_count: got %0d want 43", cycle_count);
        else n_pass++;
    endtask

    task automatic test_priority;
        int hit;
        do_reset();
        do_write(A_RELOAD, 16'd4);
        do_write(A_CTRL, 16'h0001);
        idle(3);
        do_write(A_RESULT, 16'h0000);
        n_total++;
        if (state_o !== 3'd2 || cycle_count !== 32'd4)
            $display("[TB] FAIL prio_result: got state %0d count %0d want 2 4", state_o, cycle_count);
        else n_pass++;
        do_reset();
        do_write(A_RELOAD, 16'd4);
        do_write(A_CTRL, 16'h0001);
        idle(3);
        do_write(A_CTRL, 16'h0002);
        n_total++;
        if (state_o !== 3'd1) $display("[TB] FAIL prio_kick: got %0d want 1", state_o);
        else n_pass++;
        hit = -1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (hit < 0 && state_o === 3'd4) hit = i;
        end
        n_total++;
        if (hit != 4) $display("[TB] FAIL prio_kick_expiry: got %0d want 4", hit);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        int hit;
        do_reset();
        do_write(A_RELOAD, 16'd5);
        do_write(A_CTRL, 16'h0001);
        idle(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (state_o !== 3'd0 || cycle_count !== '0 || test_done !== 1'b0)
            $display("[TB] FAIL midrst_clear: got state %0d count %0d done %b want 0 0 0",
                     state_o, cycle_count, test_done);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        do_write(A_CTRL, 16'h0001);
        n_total++;
        if (state_o !== 3'd1) $display("[TB] FAIL midrst_restart: got %0d want 1", state_o);
        else n_pass++;
        hit = -1;
        for (int i = 1; i <= TO + 100; i++) begin
            @(negedge clk);
            if (state_o === 3'd4) begin
                hit = i;
                break;
            end
        end
        n_total++;
        if (hit != TO) $display("[TB] FAIL midrst_wdog: got %0d want %0d", hit, TO);
        else n_pass++;
        n_total++;
        if (cycle_count !== 32'(TO)) $display("[TB] FAIL midrst_count: got %0d want %0d", cycle_count, TO);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_and_same_cycle();
        test_pass_flow();
        test_fail_flow();
        test_timeout_flow();
        test_kick();
        test_priority();
        test_reset_mid_run();
        $display("[TB] %0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
